// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: one outstanding memory request, PC-tagged in-order buffer
// toward decode, and a flush that discards buffered and in-flight instructions.
module inst_fetch_buffer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_misalign
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;

    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic              mis_q  [DEPTH];

    logic              aligned, can_issue, req_fire, mis_fire, rsp_push, push, pop;
    logic [DATA_W-1:0] push_inst;
    logic [ADDR_W-1:0] push_pc;
    logic              push_mis;

    always_comb begin
        aligned        = (pc_addr[1:0] == 2'b00);
        // A slot is reserved at issue time, so a returning word always fits.
        can_issue      = (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !flush;
        imem_req_valid = pc_valid && can_issue && aligned;
        imem_req_addr  = pc_addr;
        pc_ready       = pc_valid && can_issue && (!aligned || imem_req_ready);
        req_fire       = imem_req_valid && imem_req_ready;
        mis_fire       = pc_ready && !aligned;
        rsp_push       = (state_q == WAIT) && imem_rsp_valid && !flush;
        push           = rsp_push || mis_fire;
        pop            = (count_q != '0) && id_ready && !flush;

        push_inst = rsp_push ? imem_rsp_data : '0;
        push_pc   = rsp_push ? req_pc_q : pc_addr;
        push_mis  = !rsp_push;

        state_d = state_q;
        case (state_q)
            IDLE:      if (req_fire) state_d = WAIT;
            WAIT: begin
                if (imem_rsp_valid)  state_d = IDLE;
                else if (flush)      state_d = WAIT_DROP;
            end
            WAIT_DROP: if (imem_rsp_valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        req_pc_d = req_fire ? pc_addr : req_pc_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            req_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                mis_q[i]  <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            req_pc_q <= req_pc_d;
            if (push) begin
                inst_q[wr_ptr_q] <= push_inst;
                pc_q[wr_ptr_q]   <= push_pc;
                mis_q[wr_ptr_q]  <= push_mis;
            end
        end
    end

    assign id_valid    = (count_q != '0);
    assign id_inst     = inst_q[rd_ptr_q];
    assign id_pc       = pc_q[rd_ptr_q];
    assign id_misalign = mis_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed scenarios plus a randomized run against
// a queue-based model of the fetch buffer and its single outstanding request.
module tb_inst_fetch_buffer;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc_addr;
    logic        pc_ready;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
        .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
        .id_pc(id_pc), .id_misalign(id_misalign)
    );

    task automatic set_in(input logic pv, input logic [31:0] pa, input logic rr,
                          input logic rv, input logic [31:0] rd, input logic ir,
                          input logic fl);
        pc_valid = pv; pc_addr = pa; imem_req_ready = rr;
        imem_rsp_valid = rv; imem_rsp_data = rd; id_ready = ir; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({id_valid, id_inst, id_pc, id_misalign} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_id got v=%b inst=%h pc=%h mis=%b want all zero", id_valid, id_inst, id_pc, id_misalign);
        end
        checks++;
        if ({pc_ready, imem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got pc_ready=%b req_valid=%b want 0 0", pc_ready, imem_req_valid);
        end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({imem_req_valid, pc_ready, imem_req_addr} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL basic_req0 got req_valid=%b pc_ready=%b addr=%h want 1 1 0", imem_req_valid, pc_ready, imem_req_addr);
        end
        tick();
        set_in(1'b1, 32'h4, 1'b1, 1'b1, 32'h20080005, 1'b0, 1'b0);
        #1;
        checks++;
        if ({imem_req_valid, pc_ready} !== 2'b00) begin
            errors++;
            $display("FAIL basic_busy got req_valid=%b pc_ready=%b want 0 0", imem_req_valid, pc_ready);
        end
        tick();
        checks++;
        if ({id_valid, id_pc, id_inst, id_misalign} !== {1'b1, 32'h0, 32'h20080005, 1'b0}) begin
            errors++;
            $display("FAIL basic_head0 got v=%b pc=%h inst=%h mis=%b want 1 0 20080005 0", id_valid, id_pc, id_inst, id_misalign);
        end
        set_in(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({imem_req_valid, pc_ready, imem_req_addr} !== {1'b1, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL basic_req4 got req_valid=%b pc_ready=%b addr=%h want 1 1 4", imem_req_valid, pc_ready, imem_req_addr);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h2009000A, 1'b0, 1'b0);
        tick();
        checks++;
        if ({id_valid, id_pc, id_inst, id_misalign} !== {1'b1, 32'h4, 32'h2009000A, 1'b0}) begin
            errors++;
            $display("FAIL basic_head4 got v=%b pc=%h inst=%h mis=%b want 1 4 2009000a 0", id_valid, id_pc, id_inst, id_misalign);
        end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty got id_valid=%b want 0", id_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h4, 1'b1, 1'b1, 32'h11110000, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h8, 1'b1, 1'b1, 32'h11110004, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, (i == 2) ? 1'b1 : 1'b0, 1'b0);
            #1;
            checks++;
            if ({pc_ready, imem_req_valid, id_valid, id_pc} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
                errors++;
                $display("FAIL bp_full[%0d] got pc_ready=%b req_valid=%b v=%b pc=%h want 0 0 1 0", i, pc_ready, imem_req_valid, id_valid, id_pc);
            end
            tick();
        end
        set_in(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({pc_ready, imem_req_valid, id_valid, id_pc, id_inst} !== {1'b1, 1'b1, 1'b1, 32'h4, 32'h11110004}) begin
            errors++;
            $display("FAIL bp_drain1 got pc_ready=%b req_valid=%b v=%b pc=%h inst=%h want 1 1 1 4 11110004", pc_ready, imem_req_valid, id_valid, id_pc, id_inst);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h11110008, 1'b1, 1'b0);
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained got id_valid=%b want 0", id_valid);
        end
        tick();
        checks++;
        if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h8, 32'h11110008}) begin
            errors++;
            $display("FAIL bp_head8 got v=%b pc=%h inst=%h want 1 8 11110008", id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_flush_drop();
        do_reset();
        set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checks++;
        if (pc_ready !== 1'b0) begin
            errors++;
            $display("FAIL fd_flushcyc got pc_ready=%b want 0", pc_ready);
        end
        tick();
        set_in(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({pc_ready, imem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fd_waitdrop got pc_ready=%b req_valid=%b want 0 0", pc_ready, imem_req_valid);
        end
        tick();
        set_in(1'b1, 32'h40, 1'b1, 1'b1, 32'hBAD0BAD0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({pc_ready, id_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fd_rspcyc got pc_ready=%b id_valid=%b want 0 0", pc_ready, id_valid);
        end
        tick();
        set_in(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({id_valid, pc_ready, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL fd_reissue got v=%b pc_ready=%b req_valid=%b addr=%h want 0 1 1 40", id_valid, pc_ready, imem_req_valid, imem_req_addr);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h00C0FFEE, 1'b0, 1'b0);
        tick();
        checks++;
        if ({id_valid, id_pc, id_inst, id_misalign} !== {1'b1, 32'h40, 32'h00C0FFEE, 1'b0}) begin
            errors++;
            $display("FAIL fd_head40 got v=%b pc=%h inst=%h mis=%b want 1 40 00c0ffee 0", id_valid, id_pc, id_inst, id_misalign);
        end
    endtask

    task automatic test_flush_with_rsp();
        do_reset();
        set_in(1'b1, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h24, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h28, 1'b1, 1'b1, 32'hDEADDEAD, 1'b1, 1'b1);
        #1;
        checks++;
        if ({pc_ready, imem_req_valid, id_valid} !== 3'b001) begin
            errors++;
            $display("FAIL fr_pre got pc_ready=%b req_valid=%b v=%b want 0 0 1", pc_ready, imem_req_valid, id_valid);
        end
        tick();
        set_in(1'b1, 32'h28, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({id_valid, pc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL fr_post got id_valid=%b pc_ready=%b want 0 1", id_valid, pc_ready);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h00001234, 1'b0, 1'b0);
        tick();
        checks++;
        if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h28, 32'h00001234}) begin
            errors++;
            $display("FAIL fr_next got v=%b pc=%h inst=%h want 1 28 00001234", id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        set_in(1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({imem_req_valid, pc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mis_accept got req_valid=%b pc_ready=%b want 0 1", imem_req_valid, pc_ready);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({id_valid, id_pc, id_inst, id_misalign} !== {1'b1, 32'h6, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL mis_head got v=%b pc=%h inst=%h mis=%b want 1 6 0 1", id_valid, id_pc, id_inst, id_misalign);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1'b1, 32'hA, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'hBEEFBEEF, 1'b0, 1'b0);
        checks++;
        if ({id_valid, id_inst, id_pc, id_misalign} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rm_cleared got v=%b inst=%h pc=%h mis=%b want all zero", id_valid, id_inst, id_pc, id_misalign);
        end
        tick();
        set_in(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({id_valid, pc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rm_ignored got id_valid=%b pc_ready=%b want 0 1", id_valid, pc_ready);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        mis;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        bit          busy = 0, drop = 0, need_new = 1;
        int          cd = 0;
        logic [31:0] rpc = 32'h0, addr = 32'h0;
        bit          can, al, exp_req, exp_rdy, fl;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (id_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid c=%0d got %b want %b", c, id_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({id_inst, id_pc, id_misalign} !== {q[0].inst, q[0].pc, q[0].mis}) begin
                    errors++;
                    $display("FAIL rnd_head c=%0d got inst=%h pc=%h mis=%b want %h %h %b", c, id_inst, id_pc, id_misalign, q[0].inst, q[0].pc, q[0].mis);
                end
            end
            if (need_new) begin
                addr = $urandom;
                if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
                else if (addr[1:0] == 2'b00) addr[1:0] = 2'b10;
            end
            fl             = ($urandom_range(0, 11) == 0);
            flush          = fl;
            pc_valid       = ($urandom_range(0, 3) != 0);
            pc_addr        = addr;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            imem_rsp_data  = $urandom;
            if (busy) imem_rsp_valid = (cd == 0);
            else      imem_rsp_valid = ($urandom_range(0, 7) == 0);
            al      = (addr[1:0] == 2'b00);
            can     = !busy && (q.size() < DEPTH) && !fl;
            exp_req = pc_valid && can && al;
            exp_rdy = pc_valid && can && (!al || imem_req_ready);
            #1;
            checks++;
            if ({pc_ready, imem_req_valid} !== {exp_rdy, exp_req}) begin
                errors++;
                $display("FAIL rnd_comb c=%0d got pc_ready=%b req_valid=%b want %b %b", c, pc_ready, imem_req_valid, exp_rdy, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (imem_req_addr !== addr) begin
                    errors++;
                    $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_req_addr, addr);
                end
            end
            @(posedge clk);
            if (fl) q.delete();
            else if (id_ready && q.size() != 0) void'(q.pop_front());
            if (busy && imem_rsp_valid) begin
                if (!fl && !drop) begin
                    e.inst = imem_rsp_data; e.pc = rpc; e.mis = 1'b0;
                    q.push_back(e);
                end
                busy = 0;
            end else if (busy) begin
                if (fl) drop = 1;
                cd--;
            end
            if (exp_rdy && !al) begin
                e.inst = 32'h0; e.pc = addr; e.mis = 1'b1;
                q.push_back(e);
            end
            if (exp_req && imem_req_ready) begin
                busy = 1; drop = 0; rpc = addr; cd = $urandom_range(0, 3);
            end
            need_new = exp_rdy;
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_flush_drop();
        test_flush_with_rsp();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
